data_mem_arbiter: RTL and testbench



---
 rtl/data_mem_arb_pkg.sv | 16 +
 rtl/mem_rr_picker.sv | 14 +
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter: FSM states,
// requester ids and the access counter width.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational two-way round-robin selector: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module mem_rr_picker (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter and access sequencer for the shared data memory:
// grants one request, holds the memory port for ACCESS_CYCLES, then pulses ready.
import data_mem_arb_pkg::*;

module data_mem_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MEM_DEPTH     = 256,
  parameter int DATA_W        = 32
) (
  input  logic              K_clk,
  input  logic              K_reset,
  input  logic              K_req0,
  input  logic              K_req1,
  input  logic              K_we0,
  input  logic              K_we1,
  input  logic [DATA_W-1:0] K_addr0,
  input  logic [DATA_W-1:0] K_addr1,
  input  logic [DATA_W-1:0] K_wdata0,
  input  logic [DATA_W-1:0] K_wdata1,
  output logic              K_ready0,
  output logic              K_ready1,
  output logic [DATA_W-1:0] K_rdata0,
  output logic [DATA_W-1:0] K_rdata1,
  output logic              K_err,
  output logic              K_busy,
  output logic [DATA_W-1:0] K_mem_addr,
  output logic [DATA_W-1:0] K_mem_write_data,
  output logic              K_MemWrite,
  input  logic [DATA_W-1:0] K_mem_read_data
);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(MEM_DEPTH);

  arb_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              win_id;
  logic              win_we;
  logic              oor;
  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_rr_picker u_picker (
    .req0      (K_req0),
    .req1      (K_req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_we    = gnt_id ? K_we1    : K_we0;
  assign sel_addr  = gnt_id ? K_addr1  : K_addr0;
  assign sel_wdata = gnt_id ? K_wdata1 : K_wdata0;

  always_ff @(posedge K_clk) begin
    if (K_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (gnt_valid) state_next = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // The memory port registers double as the latched address/write data, so
  // they naturally hold their last values once the access is over.
  always_ff @(posedge K_clk) begin
    if (K_reset) begin
      cnt              <= '0;
      last             <= REQ_DBG;
      win_id           <= REQ_CPU;
      win_we           <= 1'b0;
      oor              <= 1'b0;
      K_mem_addr       <= '0;
      K_mem_write_data <= '0;
      K_rdata0         <= '0;
      K_rdata1         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            win_id           <= gnt_id;
            win_we           <= sel_we;
            oor              <= (sel_addr >= DEPTH_LIM);
            K_mem_addr       <= sel_addr;
            K_mem_write_data <= sel_wdata;
            cnt              <= CNT_LOAD;
            last             <= gnt_id;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (!win_we) begin
            if (win_id == REQ_CPU) K_rdata0 <= oor ? '0 : K_mem_read_data;
            else                   K_rdata1 <= oor ? '0 : K_mem_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign K_busy     = (state != ST_IDLE);
  assign K_MemWrite = (state == ST_ACCESS) && win_we && !oor;
  assign K_ready0   = (state == ST_DONE) && (win_id == REQ_CPU);
  assign K_ready1   = (state == ST_DONE) && (win_id == REQ_DBG);
  assign K_err      = (state == ST_DONE) && oor;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small memory model;
// a second instance exercises the single-cycle access configuration.
module tb_data_mem_arbiter;

  logic        K_clk = 1'b0;
  logic        K_reset = 1'b1;
  logic        K_req0 = 1'b0, K_req1 = 1'b0, K_we0 = 1'b0, K_we1 = 1'b0;
  logic [31:0] K_addr0 = '0, K_addr1 = '0, K_wdata0 = '0, K_wdata1 = '0;
  logic        K_ready0, K_ready1, K_err, K_busy, K_MemWrite;
  logic [31:0] K_rdata0, K_rdata1, K_mem_addr, K_mem_write_data, K_mem_read_data;

  logic        req2 = 1'b0;
  logic        ready2_0, ready2_1, err2, busy2, memwrite2;
  logic [31:0] rdata2_0, rdata2_1, mem_addr2, mem_wdata2, mem_rd2;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_store [256];
  logic        written   [256];

  always #5 K_clk = ~K_clk;

  data_mem_arbiter #(.ACCESS_CYCLES(2), .MEM_DEPTH(256), .DATA_W(32)) dut (
    .K_clk(K_clk), .K_reset(K_reset),
    .K_req0(K_req0), .K_req1(K_req1), .K_we0(K_we0), .K_we1(K_we1),
    .K_addr0(K_addr0), .K_addr1(K_addr1), .K_wdata0(K_wdata0), .K_wdata1(K_wdata1),
    .K_ready0(K_ready0), .K_ready1(K_ready1), .K_rdata0(K_rdata0), .K_rdata1(K_rdata1),
    .K_err(K_err), .K_busy(K_busy), .K_mem_addr(K_mem_addr),
    .K_mem_write_data(K_mem_write_data), .K_MemWrite(K_MemWrite),
    .K_mem_read_data(K_mem_read_data)
  );

  data_mem_arbiter #(.ACCESS_CYCLES(1), .MEM_DEPTH(256), .DATA_W(32)) dut1 (
    .K_clk(K_clk), .K_reset(K_reset),
    .K_req0(req2), .K_req1(1'b0), .K_we0(1'b0), .K_we1(1'b0),
    .K_addr0(32'd0), .K_addr1(32'd0), .K_wdata0(32'd0), .K_wdata1(32'd0),
    .K_ready0(ready2_0), .K_ready1(ready2_1), .K_rdata0(rdata2_0), .K_rdata1(rdata2_1),
    .K_err(err2), .K_busy(busy2), .K_mem_addr(mem_addr2),
    .K_mem_write_data(mem_wdata2), .K_MemWrite(memwrite2),
    .K_mem_read_data(mem_rd2)
  );

  // Preset words stand in for a preloaded memory until the DUT overwrites them.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (written[a] === 1'b1) return mem_store[a];
    case (a)
      8'd0:    return 32'h0BAD_F00D;
      8'd5:    return 32'hDEAD_BEEF;
      8'd44:   return 32'h0000_0055;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge K_clk) begin
    if (K_MemWrite) begin
      mem_store[K_mem_addr[7:0]] <= K_mem_write_data;
      written[K_mem_addr[7:0]]   <= 1'b1;
    end
  end

  assign K_mem_read_data = mem_word(K_mem_addr[7:0]);
  assign mem_rd2         = mem_word(mem_addr2[7:0]);

  task automatic tick();
    @(posedge K_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    K_reset = 1'b1;
    tick();
    tick();
    K_reset = 1'b0;
  endtask

  task automatic apply_stimulus(input logic port, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      K_req1 = 1'b1; K_we1 = we; K_addr1 = addr; K_wdata1 = wdata;
    end else begin
      K_req0 = 1'b1; K_we0 = we; K_addr0 = addr; K_wdata0 = wdata;
    end
  endtask

  int busy_cnt;
  int wr_cnt;

  initial begin
    apply_reset();
    check_output("rst_busy",   K_busy,           0);
    check_output("rst_ready0", K_ready0,         0);
    check_output("rst_ready1", K_ready1,         0);
    check_output("rst_err",    K_err,            0);
    check_output("rst_memwr",  K_MemWrite,       0);
    check_output("rst_maddr",  K_mem_addr,       0);
    check_output("rst_mwdata", K_mem_write_data, 0);
    check_output("rst_rdata0", K_rdata0,         0);
    check_output("rst_rdata1", K_rdata1,         0);

    $display("[TB] single read from requester 0");
    apply_stimulus(1'b0, 1'b0, 32'd5, 32'h0);
    tick();
    check_output("rd_c1_busy",   K_busy,     1);
    check_output("rd_c1_maddr",  K_mem_addr, 32'd5);
    check_output("rd_c1_memwr",  K_MemWrite, 0);
    check_output("rd_c1_ready0", K_ready0,   0);
    tick();
    check_output("rd_c2_ready0", K_ready0,   0);
    tick();
    check_output("rd_c3_ready0", K_ready0,   1);
    check_output("rd_c3_ready1", K_ready1,   0);
    check_output("rd_c3_rdata0", K_rdata0,   32'hDEAD_BEEF);
    check_output("rd_c3_err",    K_err,      0);
    K_req0 = 1'b0;
    tick();
    check_output("rd_c4_ready0", K_ready0,   0);
    check_output("rd_c4_busy",   K_busy,     0);
    check_output("rd_c4_hold",   K_rdata0,   32'hDEAD_BEEF);

    $display("[TB] write then read from requester 1");
    apply_stimulus(1'b1, 1'b1, 32'd10, 32'h1234);
    wr_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (K_MemWrite) wr_cnt++;
      if (c <= 2) begin
        check_output("wr_maddr",  K_mem_addr,       32'd10);
        check_output("wr_mwdata", K_mem_write_data, 32'h1234);
      end
      if (c == 3) begin
        check_output("wr_ready1", K_ready1, 1);
        check_output("wr_rdata1", K_rdata1, 0);
        K_req1 = 1'b0;
      end
    end
    check_output("wr_memwr_cycles", wr_cnt, 2);
    check_output("wr_mem10",        mem_word(8'd10), 32'h1234);
    apply_stimulus(1'b1, 1'b0, 32'd10, 32'h0);
    tick(); tick(); tick();
    check_output("rb_ready1", K_ready1, 1);
    check_output("rb_rdata1", K_rdata1, 32'h1234);
    K_req1 = 1'b0;
    tick();

    $display("[TB] contention with both requests held");
    apply_reset();
    apply_stimulus(1'b0, 1'b0, 32'd5,  32'h0);
    apply_stimulus(1'b1, 1'b0, 32'd10, 32'h0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      check_output($sformatf("ct_c%0d_ready0", c), K_ready0, (c == 3 || c == 11));
      check_output($sformatf("ct_c%0d_ready1", c), K_ready1, (c == 7));
    end
    check_output("ct_rdata0", K_rdata0, 32'hDEAD_BEEF);
    check_output("ct_rdata1", K_rdata1, 32'h1234);
    K_req0 = 1'b0;
    K_req1 = 1'b0;
    tick();

    $display("[TB] out-of-range write and read");
    apply_stimulus(1'b0, 1'b1, 32'd300, 32'hFFFF_FFFF);
    wr_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (K_MemWrite) wr_cnt++;
    end
    check_output("oor_memwr_cycles", wr_cnt, 0);
    check_output("oor_ready0", K_ready0, 1);
    check_output("oor_err",    K_err,    1);
    K_req0 = 1'b0;
    tick();
    check_output("oor_err_clear", K_err, 0);
    check_output("oor_mem44",     mem_word(8'd44), 32'h55);
    apply_stimulus(1'b0, 1'b0, 32'd300, 32'h0);
    tick(); tick(); tick();
    check_output("oor_rd_err",    K_err,    1);
    check_output("oor_rd_rdata0", K_rdata0, 0);
    K_req0 = 1'b0;
    tick();

    $display("[TB] reset during an access");
    apply_stimulus(1'b0, 1'b1, 32'd20, 32'hABCD);
    tick();
    check_output("mr_c1_memwr", K_MemWrite, 1);
    K_reset = 1'b1;
    K_req0  = 1'b0;
    tick();
    check_output("mr_memwr",  K_MemWrite, 0);
    check_output("mr_ready0", K_ready0,   0);
    check_output("mr_busy",   K_busy,     0);
    check_output("mr_rdata0", K_rdata0,   0);
    K_reset = 1'b0;
    tick();
    check_output("mr_idle_ready0", K_ready0, 0);
    apply_stimulus(1'b0, 1'b0, 32'd5, 32'h0);
    tick(); tick(); tick();
    check_output("mr_fresh_ready0", K_ready0, 1);
    check_output("mr_fresh_rdata0", K_rdata0, 32'hDEAD_BEEF);
    K_req0 = 1'b0;
    tick();

    $display("[TB] single-cycle access configuration");
    req2 = 1'b1;
    busy_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (busy2) busy_cnt++;
      check_output($sformatf("ac1_c%0d_ready", c), ready2_0, (c == 2));
      if (c == 2) begin
        check_output("ac1_rdata", rdata2_0, 32'h0BAD_F00D);
        req2 = 1'b0;
      end
    end
    check_output("ac1_busy_cycles", busy_cnt, 2);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
